// File: rtl/acquisition_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : acquisition_controller_if
// Purpose  : Sample-RAM port and UART transmitter handshake of the
//            acquisition controller, bundled as one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface acquisition_controller_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 10
);
    logic                 o_mem_we;
    logic [ADDR_SIZE-1:0] o_mem_addr;
    logic [DATA_SIZE-1:0] o_mem_wdata;
    logic [DATA_SIZE-1:0] i_mem_rdata;
    logic                 o_tx_start;
    logic [7:0]           o_tx_data;
    logic                 i_tx_busy;

    modport master (
        output o_mem_we, o_mem_addr, o_mem_wdata, o_tx_start, o_tx_data,
        input  i_mem_rdata, i_tx_busy
    );

    modport slave (
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_tx_start, o_tx_data,
        output i_mem_rdata, i_tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/acquisition_controller.sv
`default_nettype none
// ============================================================================
// Module   : acquisition_controller
// Purpose  : Captures DEPTH decimated samples into the sample RAM, then
//            streams them byte by byte to the UART transmitter.
//            Define ACQ_HEADER_EN to prefix the readout with {4'hA, decim}.
// Revision : 1.0 - initial release
// ============================================================================
module acquisition_controller #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 10,
    parameter int DEPTH     = 1024
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_reset,
    input  logic                 i_cmd_sample,
    input  logic                 i_cmd_set_decim,
    input  logic [3:0]           i_cmd_param,
    input  logic                 i_sample_valid,
    input  logic [DATA_SIZE-1:0] i_sample,
    acquisition_controller_if.master bus,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [ADDR_SIZE-1:0] c_last_addr = ADDR_SIZE'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_HEADER  = 3'd2,
        S_READ    = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t                r_state,       w_state_n;
    logic [3:0]            r_decim,       w_decim_n;
    logic [3:0]            r_cap_decim,   w_cap_decim_n;
    logic [3:0]            r_dcnt,        w_dcnt_n;
    logic [ADDR_SIZE-1:0]  r_addr,        w_addr_n;
    logic                  r_mem_we,      w_mem_we_n;
    logic [DATA_SIZE-1:0]  r_mem_wdata,   w_mem_wdata_n;
    logic                  r_tx_start,    w_tx_start_n;
    logic [7:0]            r_tx_data,     w_tx_data_n;
    logic                  r_done,        w_done_n;
    logic                  r_hdr_pend,    w_hdr_pend_n;
    logic                  r_cmd_sample_q;
    logic                  w_sample_rise;

    assign w_sample_rise = i_cmd_sample & ~r_cmd_sample_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_decim        <= 4'd0;
            r_cap_decim    <= 4'd0;
            r_dcnt         <= 4'd0;
            r_addr         <= '0;
            r_mem_we       <= 1'b0;
            r_mem_wdata    <= '0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'd0;
            r_done         <= 1'b0;
            r_hdr_pend     <= 1'b0;
            r_cmd_sample_q <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_decim        <= w_decim_n;
            r_cap_decim    <= w_cap_decim_n;
            r_dcnt         <= w_dcnt_n;
            r_addr         <= w_addr_n;
            r_mem_we       <= w_mem_we_n;
            r_mem_wdata    <= w_mem_wdata_n;
            r_tx_start     <= w_tx_start_n;
            r_tx_data      <= w_tx_data_n;
            r_done         <= w_done_n;
            r_hdr_pend     <= w_hdr_pend_n;
            r_cmd_sample_q <= i_cmd_sample;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_decim_n     = r_decim;
        w_cap_decim_n = r_cap_decim;
        w_dcnt_n      = r_dcnt;
        w_addr_n      = r_addr;
        w_mem_we_n    = 1'b0;
        w_mem_wdata_n = r_mem_wdata;
        w_tx_start_n  = 1'b0;
        w_tx_data_n   = r_tx_data;
        w_done_n      = 1'b0;
        w_hdr_pend_n  = r_hdr_pend;

        if (i_cmd_reset) begin
            w_state_n    = S_IDLE;
            w_hdr_pend_n = 1'b0;
        end else begin
            if (i_cmd_set_decim) begin
                w_decim_n = i_cmd_param;
            end
            case (r_state)
                S_IDLE: begin
                    // The factor is frozen here so a later set_decim only hits the next capture.
                    if (w_sample_rise && !i_cmd_set_decim) begin
                        w_state_n     = S_CAPTURE;
                        w_addr_n      = '0;
                        w_dcnt_n      = 4'd0;
                        w_cap_decim_n = r_decim;
                        w_hdr_pend_n  = 1'b0;
                    end
                end
                S_CAPTURE: begin
                    // r_addr points at the word being written while r_mem_we is high;
                    // it advances in the following cycle.
                    if (r_mem_we && (r_addr == c_last_addr)) begin
`ifdef ACQ_HEADER_EN
                        w_state_n = S_HEADER;
`else
                        w_state_n = S_READ;
`endif
                        w_addr_n  = '0;
                    end else begin
                        if (r_mem_we) begin
                            w_addr_n = r_addr + 1'b1;
                        end
                        if (i_sample_valid) begin
                            if (r_dcnt == 4'd0) begin
                                w_mem_we_n    = 1'b1;
                                w_mem_wdata_n = i_sample;
                                w_dcnt_n      = r_cap_decim;
                            end else begin
                                w_dcnt_n = r_dcnt - 1'b1;
                            end
                        end
                    end
                end
`ifdef ACQ_HEADER_EN
                S_HEADER: begin
                    if (!bus.i_tx_busy) begin
                        w_tx_data_n  = {4'hA, r_cap_decim};
                        w_tx_start_n = 1'b1;
                        w_hdr_pend_n = 1'b1;
                        w_state_n    = S_WAIT_TX;
                    end
                end
`endif
                S_READ: begin
                    w_state_n = S_SEND;
                end
                S_SEND: begin
                    if (!bus.i_tx_busy) begin
                        w_tx_data_n  = 8'(bus.i_mem_rdata);
                        w_tx_start_n = 1'b1;
                        w_state_n    = S_WAIT_TX;
                    end
                end
                S_WAIT_TX: begin
                    // Busy only rises the cycle after the start pulse, so that cycle is skipped.
                    if (!r_tx_start && !bus.i_tx_busy) begin
                        if (r_hdr_pend) begin
                            w_hdr_pend_n = 1'b0;
                            w_state_n    = S_READ;
                        end else if (r_addr == c_last_addr) begin
                            w_done_n  = 1'b1;
                            w_state_n = S_IDLE;
                        end else begin
                            w_addr_n  = r_addr + 1'b1;
                            w_state_n = S_READ;
                        end
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_addr  = r_addr;
    assign bus.o_mem_wdata = r_mem_wdata;
    assign bus.o_tx_start  = r_tx_start;
    assign bus.o_tx_data   = r_tx_data;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = r_done;

endmodule
`default_nettype wire
